// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// serial_adder_pkg : state encodings and width limits for the serial adder
// Revision: 1.0
// ============================================================================
package serial_adder_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    // Bit-counter width; clamped so a degenerate WIDTH still elaborates far
    // enough to reach the range check.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/serial_adder_if.sv
`default_nettype none
// ============================================================================
// serial_adder_if : request/result bundle between a requester and serial_adder
// Revision: 1.0
// ============================================================================
interface serial_adder_if #(
    parameter int WIDTH = 8
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );

endinterface : serial_adder_if
`default_nettype wire

// File: rtl/fa_bit.sv
`default_nettype none
// ============================================================================
// fa_bit : combinational one-bit full adder, the serial adder's datapath cell
// Revision: 1.0
// ============================================================================
module fa_bit (
    input  wire logic a_i,
    input  wire logic b_i,
    input  wire logic cin_i,
    output logic      s_o,
    output logic      co_o
);

    assign s_o  = a_i ^ b_i ^ cin_i;
    assign co_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule : fa_bit
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// serial_adder : LSB-first bit-serial adder, one full-adder cell, WIDTH cycles
// Revision: 1.0
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    serial_adder_if.slave  sa_if
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
        $fatal(1, "serial_adder: WIDTH out of range");
    end

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_sr_q,   a_sr_d;
    logic [WIDTH-1:0] b_sr_q,   b_sr_d;
    logic             carry_q,  carry_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] part_q,   part_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             cout_q,   cout_d;

    logic w_fa_s;
    logic w_fa_co;
    logic w_accept;
    logic w_shift;
    logic w_last;

    fa_bit u_fa (
        .a_i   (a_sr_q[0]),
        .b_i   (b_sr_q[0]),
        .cin_i (carry_q),
        .s_o   (w_fa_s),
        .co_o  (w_fa_co)
    );

    assign w_accept = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && sa_if.start;
    assign w_shift  = (state_q == ST_SHIFT);
    assign w_last   = w_shift && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        part_d  = part_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            ST_IDLE:  if (sa_if.start) state_d = ST_SHIFT;
            ST_SHIFT: if (w_last)      state_d = ST_DONE;
            ST_DONE:  state_d = sa_if.start ? ST_SHIFT : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (w_accept) begin
            a_sr_d  = sa_if.a;
            b_sr_d  = sa_if.b;
            carry_d = sa_if.cin;
            cnt_d   = '0;
            part_d  = '0;
        end else if (w_shift) begin
            // Sum bits enter at the MSB so the LSB lands in bit 0 after WIDTH shifts.
            a_sr_d  = a_sr_q >> 1;
            b_sr_d  = b_sr_q >> 1;
            carry_d = w_fa_co;
            cnt_d   = cnt_q + CNT_W'(1);
            part_d  = {w_fa_s, part_q[WIDTH-1:1]};
        end

        if (w_last) begin
            sum_d  = {w_fa_s, part_q[WIDTH-1:1]};
            cout_d = w_fa_co;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            part_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            part_q  <= part_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign sa_if.busy = (state_q == ST_SHIFT);
    assign sa_if.done = (state_q == ST_DONE);
    assign sa_if.sum  = sum_q;
    assign sa_if.cout = cout_q;

endmodule : serial_adder
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// tb_serial_adder : vector table, corner sequences and random operands vs a+b+cin
// Revision: 1.0
// ============================================================================
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) if8 ();
    serial_adder_if #(.WIDTH(2)) if2 ();

    serial_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .sa_if(if8));
    serial_adder #(.WIDTH(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .sa_if(if2));

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [32:0] got, input logic [32:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic get_done(input int w);
        return (w == 8) ? if8.done : if2.done;
    endfunction

    function automatic logic get_busy(input int w);
        return (w == 8) ? if8.busy : if2.busy;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated addition; returns result, start-to-done latency, busy cycles
    // and the done level one cycle after the pulse.
    task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, output logic [32:0] res, output int lat,
                          output int busy_cnt, output logic done_after);
        if (w == 8) begin
            if8.start = 1'b1; if8.a = a[7:0]; if8.b = b[7:0]; if8.cin = cin;
        end else begin
            if2.start = 1'b1; if2.a = a[1:0]; if2.b = b[1:0]; if2.cin = cin;
        end
        tick();
        if8.start = 1'b0; if8.a = 8'($urandom); if8.b = 8'($urandom);
        if2.start = 1'b0; if2.a = 2'($urandom); if2.b = 2'($urandom);
        lat = 0;
        busy_cnt = 0;
        while (!get_done(w) && lat < 64) begin
            if (get_busy(w)) busy_cnt++;
            tick();
            lat++;
        end
        res = (w == 8) ? 33'({if8.cout, if8.sum}) : 33'({if2.cout, if2.sum});
        tick();
        done_after = get_done(w);
    endtask

    initial begin
        logic [32:0] res;
        logic [32:0] exp;
        logic        dn_after;
        int          lat;
        int          bcnt;
        int          cyc;
        int          last;
        int          n_done;
        logic        prev_done;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        vecs[6] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};

        rst_n = 1'b0;
        if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
        if2.start = 1'b0; if2.a = '0; if2.b = '0; if2.cin = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("reset_state8", 33'({if8.busy, if8.done, if8.cout, if8.sum}), 33'd0);
        check("reset_state2", 33'({if2.busy, if2.done, if2.cout, if2.sum}), 33'd0);

        foreach (vecs[i]) begin
            run_op(8, 32'(vecs[i].a), 32'(vecs[i].b), vecs[i].cin, res, lat, bcnt, dn_after);
            check($sformatf("vec%0d_result", i), res, 33'({vecs[i].co, vecs[i].s}));
            check($sformatf("vec%0d_latency", i), 33'(lat), 33'd8);
            check($sformatf("vec%0d_busy_cycles", i), 33'(bcnt), 33'd8);
            check($sformatf("vec%0d_done_width", i), 33'(dn_after), 33'd0);
        end

        // start pulsed mid-operation must be ignored
        if8.start = 1'b1; if8.a = 8'h01; if8.b = 8'h01; if8.cin = 1'b0;
        tick();
        if8.start = 1'b0;
        cyc = 0;
        repeat (3) begin tick(); cyc++; end
        if8.start = 1'b1; if8.a = 8'hF0;
        tick(); cyc++;
        if8.start = 1'b0;
        while (!if8.done && cyc < 64) begin tick(); cyc++; end
        check("ignore_start_latency", 33'(cyc), 33'd8);
        check("ignore_start_result", 33'({if8.cout, if8.sum}), 33'h002);
        tick();

        // start held high: back-to-back operations
        if8.start = 1'b1; if8.a = 8'h10; if8.b = 8'h20; if8.cin = 1'b0;
        tick();
        last = -1; n_done = 0; prev_done = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (if8.done) begin
                check("b2b_single_cycle", 33'(prev_done), 33'd0);
                check("b2b_sum", 33'({if8.cout, if8.sum}), 33'h030);
                if (last >= 0) check("b2b_period", 33'(c - last), 33'd9);
                else           check("b2b_first_done", 33'(c), 33'd8);
                last = c;
                n_done++;
            end
            prev_done = if8.done;
        end
        check("b2b_done_count", 33'(n_done), 33'd3);
        if8.start = 1'b0;
        cyc = 0;
        while ((if8.busy || if8.done) && cyc < 40) begin tick(); cyc++; end
        check("b2b_drain", 33'({if8.busy, if8.done}), 33'd0);

        // asynchronous reset in mid-operation
        if8.start = 1'b1; if8.a = 8'h33; if8.b = 8'h44; if8.cin = 1'b1;
        tick();
        if8.start = 1'b0;
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        check("reset_abort_outputs", 33'({if8.busy, if8.done, if8.cout, if8.sum}), 33'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        repeat (15) begin tick(); if (if8.done) n_done++; end
        check("reset_no_done", 33'(n_done), 33'd0);
        run_op(8, 32'h12, 32'h34, 1'b0, res, lat, bcnt, dn_after);
        check("post_reset_result", res, 33'h046);
        check("post_reset_latency", 33'(lat), 33'd8);

        // random operands against plain arithmetic, both widths
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom & 32'hFF; rb = $urandom & 32'hFF; rc = 1'($urandom);
            exp = 33'(ra) + 33'(rb) + 33'(rc);
            run_op(8, ra, rb, rc, res, lat, bcnt, dn_after);
            check($sformatf("rand8 %0h+%0h+%0d", ra, rb, rc), res, exp);
            check("rand8_latency", 33'(lat), 33'd8);
        end
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom & 32'h3; rb = $urandom & 32'h3; rc = 1'($urandom);
            exp = 33'(ra) + 33'(rb) + 33'(rc);
            run_op(2, ra, rb, rc, res, lat, bcnt, dn_after);
            check($sformatf("rand2 %0h+%0h+%0d", ra, rb, rc), res, exp);
            check("rand2_latency", 33'(lat), 33'd2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_serial_adder
`default_nettype wire
